// File: rtl/inst_stream_pkg.sv
// Shared types and constants for the instruction streamer.
// Latency: n/a (types, constants and a pure helper function).
// Backpressure: n/a.
package inst_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Word driven toward the core whenever nothing real is being issued.
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  // Width of the issued-word counter.
  localparam int ISSUED_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ISSUED_W-1:0] sat_inc(input logic [ISSUED_W-1:0] v);
    return (&v) ? v : v + ISSUED_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter for full/empty/level.
// Latency: head word is combinational on rdata; a push is visible on rdata the next cycle.
// Backpressure: pushes while full and pops while empty are ignored; clear flushes everything.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push_eff;
  logic             pop_eff;

  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign rdata    = mem[rd_ptr];
  assign push_eff = push && !full && !clear;
  assign pop_eff  = pop && !empty && !clear;

  // Storage array; contents need no reset because the counter guards every read.
  always_ff @(posedge clk) begin
    if (push_eff) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally (power-of-two depth); the counter tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_eff) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_eff, pop_eff})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_streamer.sv
// Instruction-stream source: buffers loader words, then issues one per cycle to the cpu core.
// Latency: popped word is registered onto o_inst; push-to-issue is 2 cycles once primed.
// Backpressure: o_wr_ready drops when full or once the last word is taken; i_stall freezes issue and drain.
module inst_streamer
  import inst_stream_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                DEPTH        = 16,
  parameter int                PRIME_LVL    = 4,
  parameter int                DRAIN_CYCLES = 10,
  parameter logic [DATA_W-1:0] NOP_WORD     = DATA_W'(NOP_DEFAULT)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_go,
  input  logic                         i_clear,
  input  logic                         i_wr_valid,
  input  logic [DATA_W-1:0]            i_wr_data,
  input  logic                         i_wr_last,
  output logic                         o_wr_ready,
  input  logic                         i_stall,
  output logic                         o_start,
  output logic [DATA_W-1:0]            o_inst,
  output logic                         o_done,
  output logic                         o_underflow,
  output logic [ISSUED_W-1:0]          o_issued,
  output logic [$clog2(DEPTH+1)-1:0]   o_level
);

  localparam int LVL_W  = $clog2(DEPTH+1);
  localparam int DCNT_W = $clog2(DRAIN_CYCLES+1);

  state_e              state;
  logic                last_seen;
  logic [DCNT_W-1:0]   drain_cnt;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W:0]     fifo_rdata;
  logic [LVL_W-1:0]    fifo_level;
  logic                head_last;
  logic                push_state_ok;
  logic                primed;

  // Ready depends only on registered state and occupancy, never on i_wr_valid.
  assign push_state_ok = (state == IDLE) || (state == PRIME) || (state == RUN);
  assign o_wr_ready    = i_rst_n && !fifo_full && !last_seen && push_state_ok;
  assign fifo_push     = i_wr_valid && o_wr_ready;
  assign fifo_pop      = (state == RUN) && !i_stall && !fifo_empty && !i_clear;
  assign head_last     = fifo_rdata[DATA_W];
  assign primed        = (fifo_level >= LVL_W'(PRIME_LVL)) || last_seen;
  assign o_level       = fifo_level;

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .clear (i_clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({i_wr_last, i_wr_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Sequencer: prime, issue (one word per unstalled cycle), pad with NOPs, then report done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      last_seen   <= 1'b0;
      drain_cnt   <= '0;
      o_start     <= 1'b0;
      o_inst      <= NOP_WORD;
      o_done      <= 1'b0;
      o_underflow <= 1'b0;
      o_issued    <= '0;
    end else if (i_clear) begin
      state       <= IDLE;
      last_seen   <= 1'b0;
      drain_cnt   <= '0;
      o_start     <= 1'b0;
      o_inst      <= NOP_WORD;
      o_done      <= 1'b0;
      o_underflow <= 1'b0;
      o_issued    <= '0;
    end else begin
      if (fifo_push && i_wr_last) begin
        last_seen <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (i_go) begin
            state <= PRIME;
          end
        end
        PRIME: begin
          if (primed) begin
            state <= RUN;
          end
        end
        RUN: begin
          // o_start rises on the first unstalled edge, together with the first word.
          if (!i_stall) begin
            o_start <= 1'b1;
            if (!fifo_empty) begin
              o_inst   <= fifo_rdata[DATA_W-1:0];
              o_issued <= sat_inc(o_issued);
              if (head_last) begin
                state     <= DRAIN;
                drain_cnt <= '0;
              end
            end else begin
              o_inst      <= NOP_WORD;
              o_underflow <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // Each unstalled edge consumes the word on o_inst and presents a NOP; the
          // counter tracks NOPs presented so the core sees DRAIN_CYCLES of them.
          if (!i_stall) begin
            o_inst <= NOP_WORD;
            if (drain_cnt == DCNT_W'(DRAIN_CYCLES)) begin
              state   <= DONE;
              o_start <= 1'b0;
              o_done  <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + DCNT_W'(1);
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_streamer.sv
// Bench for inst_streamer: directed scenarios plus randomized programs.
// A monitor models the core as a consumer and scores the stream against pushed words.
// Loader and stall are driven after the rising edge; everything is sampled on the falling edge.
module tb_inst_streamer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int DRAIN  = 10;
  localparam logic [31:0] NOP = 32'h0;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_go;
  logic        i_clear;
  logic        i_wr_valid;
  logic [31:0] i_wr_data;
  logic        i_wr_last;
  logic        o_wr_ready;
  logic        i_stall;
  logic        o_start;
  logic [31:0] o_inst;
  logic        o_done;
  logic        o_underflow;
  logic [15:0] o_issued;
  logic [4:0]  o_level;

  int errors = 0;
  int checks = 0;

  bit force_stall = 0;
  int stall_pct = 0;
  int serial = 1;

  // Consumer-side model state.
  logic [32:0] exp_q[$];
  int  consumed = 0;
  int  gaps = 0;
  int  drain_nops = 0;
  bit  last_consumed = 0;
  bit  done_checked = 0;

  inst_streamer #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .PRIME_LVL(4), .DRAIN_CYCLES(DRAIN), .NOP_WORD(NOP)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_go(i_go), .i_clear(i_clear),
    .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .i_wr_last(i_wr_last),
    .o_wr_ready(o_wr_ready), .i_stall(i_stall), .o_start(o_start), .o_inst(o_inst),
    .o_done(o_done), .o_underflow(o_underflow), .o_issued(o_issued), .o_level(o_level)
  );

  initial begin
    i_clk = 0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, required event within budget", name);
  endtask

  function automatic logic [31:0] mkword();
    logic [31:0] r;
    r = $urandom;
    serial++;
    return {r[31:12], 12'(serial)};
  endfunction

  task automatic sync();
    @(posedge i_clk);
    #1;
  endtask

  // Drive one word and hold it until accepted; returns just after the accepting edge.
  task automatic push_word(input logic [31:0] d, input logic last);
    int  t;
    bit  acc;
    t = 0;
    acc = 0;
    i_wr_valid = 1;
    i_wr_data  = d;
    i_wr_last  = last;
    while (!acc) begin
      @(negedge i_clk);
      acc = o_wr_ready;
      sync();
      t++;
      if (t > 3000) begin
        timeout("push_accept");
        acc = 1;
      end
    end
    i_wr_valid = 0;
    i_wr_last  = 0;
  endtask

  task automatic pulse_go();
    i_go = 1;
    sync();
    i_go = 0;
  endtask

  task automatic pulse_clear();
    i_clear = 1;
    sync();
    i_clear = 0;
  endtask

  task automatic wait_issued(input int n);
    int t;
    t = 0;
    while (!(o_issued >= 16'(n) && o_start)) begin
      @(negedge i_clk);
      t++;
      if (t > 3000) begin
        timeout("wait_issued");
        return;
      end
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!o_done) begin
      @(negedge i_clk);
      t++;
      if (t > 5000) begin
        timeout("wait_done");
        return;
      end
    end
  endtask

  task automatic finish_program();
    wait_done();
    sync();
    pulse_clear();
  endtask

  // Stall driver: directed override or random percentage.
  initial begin
    i_stall = 0;
    forever begin
      @(posedge i_clk);
      #2;
      i_stall = force_stall || (stall_pct > 0 && $urandom_range(99) < stall_pct);
    end
  end

  // Monitor: a word is consumed by the core on every edge where o_start is high and i_stall is low.
  always @(negedge i_clk) begin
    logic [32:0] item;
    if (!i_rst_n || i_clear) begin
      exp_q.delete();
      consumed = 0;
      gaps = 0;
      drain_nops = 0;
      last_consumed = 0;
      done_checked = 0;
    end else begin
      chk("level_bound", 64'(o_level <= 5'(DEPTH)), 64'd1);
      if (o_level == 5'(DEPTH)) chk("ready_at_full", 64'(o_wr_ready), 64'd0);
      if (o_start && !i_stall) begin
        if (!last_consumed) begin
          if (o_inst == NOP) begin
            gaps++;
          end else if (exp_q.size() == 0) begin
            chk("unexpected_word", 64'(o_inst), 64'(NOP));
          end else begin
            item = exp_q.pop_front();
            chk("stream_word", 64'(o_inst), 64'(item[31:0]));
            consumed++;
            if (item[32]) last_consumed = 1;
          end
        end else begin
          chk("drain_word", 64'(o_inst), 64'(NOP));
          drain_nops++;
        end
      end
      if (o_done && !done_checked) begin
        done_checked = 1;
        chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("done_drain_nops", 64'(drain_nops), 64'(DRAIN));
        chk("done_issued", 64'(o_issued), 64'(consumed));
        chk("done_underflow", 64'(o_underflow), 64'(gaps > 0));
        chk("done_start_low", 64'(o_start), 64'd0);
      end
      if (i_wr_valid && o_wr_ready) exp_q.push_back({i_wr_last, i_wr_data});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] basic [6];
    logic [31:0] held;
    int t;
    int len;
    basic[0] = 32'h00500093; basic[1] = 32'h00A00113; basic[2] = 32'h00F00193;
    basic[3] = 32'h01400213; basic[4] = 32'h01900293; basic[5] = 32'h01E00313;

    i_rst_n = 0; i_go = 0; i_clear = 0;
    i_wr_valid = 0; i_wr_data = '0; i_wr_last = 0;

    // Reset values.
    #3;
    chk("rst_start", 64'(o_start), 64'd0);
    chk("rst_inst", 64'(o_inst), 64'(NOP));
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_underflow", 64'(o_underflow), 64'd0);
    chk("rst_issued", 64'(o_issued), 64'd0);
    chk("rst_level", 64'(o_level), 64'd0);
    chk("rst_ready", 64'(o_wr_ready), 64'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1;
    #1 chk("ready_after_release", 64'(o_wr_ready), 64'd1);
    sync();

    // Basic run: preload 6 words, then go.
    for (int i = 0; i < 6; i++) push_word(basic[i], i == 5);
    chk("basic_ready_after_last", 64'(o_wr_ready), 64'd0);
    pulse_go();
    t = 0;
    while (!o_start && t < 100) begin
      @(negedge i_clk);
      t++;
    end
    chk("basic_first_word", 64'(o_inst), 64'(basic[0]));
    finish_program();

    // Backpressure: 20 words through a 16-deep buffer.
    for (int i = 0; i < 16; i++) push_word(mkword(), 1'b0);
    @(negedge i_clk);
    chk("bp_level_full", 64'(o_level), 64'd16);
    chk("bp_ready_full", 64'(o_wr_ready), 64'd0);
    sync();
    fork
      pulse_go();
      for (int i = 0; i < 4; i++) push_word(mkword(), i == 3);
    join
    finish_program();

    // Stall mid-RUN for 3 cycles, then again during DRAIN.
    for (int i = 0; i < 8; i++) push_word(mkword(), i == 7);
    pulse_go();
    wait_issued(3);
    sync();
    force_stall = 1;
    #2 held = o_inst;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("stall_hold", 64'(o_inst), 64'(held));
      @(posedge i_clk);
    end
    #1 force_stall = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("stall_release", 64'(o_inst !== held), 64'd1);
    wait_issued(8);
    sync();
    force_stall = 1;
    repeat (3) sync();
    force_stall = 0;
    finish_program();

    // Underflow: loader pauses after 4 words.
    for (int i = 0; i < 4; i++) push_word(mkword(), 1'b0);
    pulse_go();
    wait_issued(4);
    repeat (3) @(negedge i_clk);
    chk("uf_gap_nop", 64'(o_inst), 64'(NOP));
    chk("uf_sticky", 64'(o_underflow), 64'd1);
    sync();
    sync();
    push_word(mkword(), 1'b1);
    wait_done();
    chk("uf_final_flag", 64'(o_underflow), 64'd1);
    chk("uf_final_issued", 64'(o_issued), 64'd5);
    sync();
    pulse_clear();

    // Randomized programs with loader gaps and random stalls.
    for (int p = 0; p < 6; p++) begin
      len = (p == 0) ? 1 : int'($urandom_range(2, 24));
      stall_pct = int'($urandom_range(0, 30));
      fork
        begin
          for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 3)) sync();
            push_word(mkword(), i == len - 1);
          end
        end
        begin
          repeat ($urandom_range(0, 6)) sync();
          pulse_go();
        end
      join
      finish_program();
    end
    stall_pct = 0;
    repeat (3) sync();

    // Clear in RUN with words still buffered.
    for (int i = 0; i < 12; i++) push_word(mkword(), 1'b0);
    pulse_go();
    t = 0;
    while (!(o_start && o_level == 5'd7) && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    if (t >= 200) timeout("clear_wait_level");
    sync();
    pulse_clear();
    @(negedge i_clk);
    chk("clr_level", 64'(o_level), 64'd0);
    chk("clr_start", 64'(o_start), 64'd0);
    chk("clr_issued", 64'(o_issued), 64'd0);
    chk("clr_inst", 64'(o_inst), 64'(NOP));
    chk("clr_ready", 64'(o_wr_ready), 64'd1);
    sync();

    // Asynchronous reset in DRAIN.
    for (int i = 0; i < 5; i++) push_word(mkword(), i == 4);
    pulse_go();
    wait_issued(5);
    #2 i_rst_n = 0;
    #1;
    chk("arst_start", 64'(o_start), 64'd0);
    chk("arst_inst", 64'(o_inst), 64'(NOP));
    chk("arst_done", 64'(o_done), 64'd0);
    chk("arst_issued", 64'(o_issued), 64'd0);
    chk("arst_level", 64'(o_level), 64'd0);
    chk("arst_ready", 64'(o_wr_ready), 64'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1;
    #1 chk("arst_ready_release", 64'(o_wr_ready), 64'd1);
    repeat (3) sync();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
